// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 decode definitions: prefix bytes, lock keys, FSM states and event layout.
package ps2_pkg;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam logic [7:0] PS2_E1 = 8'hE1;

  localparam logic [7:0] KEY_CAPS   = 8'h58;
  localparam logic [7:0] KEY_NUM    = 8'h77;
  localparam logic [7:0] KEY_SCROLL = 8'h7E;

  // Index matches the ps2_lock_control bit position.
  localparam logic [7:0] LOCK_KEYS [3] = '{KEY_SCROLL, KEY_NUM, KEY_CAPS};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } prefix_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  localparam int unsigned EVENT_W = $bits(key_event_t);

  // Keyboard status/ack bytes that never start a key event.
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; push and pop may coincide, including when full.
module ps2_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign o_valid = (r_count != '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop && o_valid;
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && w_full && !w_pop;
  // Head is zeroed while empty so the event outputs read 0 out of reset.
  assign o_data  = o_valid ? r_mem[r_rd] : '0;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 decoder: folds E0/F0 prefixes into key events, queues them, tracks lock LEDs.
// Lock tracking is built only when PS2_LOCK_TRACK_EN is defined.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_action,
  input  logic [7:0] scan_code,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [2:0] ps2_lock_control,
  output logic       overflow
);

  prefix_state_t r_state;
  prefix_state_t w_next;
  logic          w_emit;
  logic          w_ext;
  logic          w_brk;
  logic          w_drop;
  logic          r_overflow;
  key_event_t    w_push_ev;
  key_event_t    w_head;

  always_comb begin
    w_next = r_state;
    w_emit = 1'b0;
    w_ext  = 1'b0;
    w_brk  = 1'b0;
    if (key_action) begin
      case (r_state)
        ST_IDLE: begin
          if (scan_code == PS2_E0)      w_next = ST_EXT;
          else if (scan_code == PS2_F0) w_next = ST_BRK;
          else if (!is_discard(scan_code)) w_emit = 1'b1;
        end
        ST_EXT: begin
          if (scan_code == PS2_F0)      w_next = ST_EXT_BRK;
          else if (scan_code == PS2_E0) w_next = ST_EXT;
          else if (scan_code == PS2_E1) w_next = ST_IDLE;
          else begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
            w_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (scan_code == PS2_F0)      w_next = ST_BRK;
          else if (scan_code == PS2_E0) w_next = ST_EXT_BRK;
          else if (scan_code == PS2_E1) w_next = ST_IDLE;
          else begin
            w_emit = 1'b1;
            w_brk  = 1'b1;
            w_next = ST_IDLE;
          end
        end
        default: begin
          if (scan_code == PS2_E0 || scan_code == PS2_F0) w_next = ST_EXT_BRK;
          else if (scan_code == PS2_E1) w_next = ST_IDLE;
          else begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
            w_brk  = 1'b1;
            w_next = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  assign w_push_ev = '{ext: w_ext, brk: w_brk, code: scan_code};

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVENT_W)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst     (reset),
    .i_push  (w_emit),
    .i_data  (w_push_ev),
    .i_pop   (ev_ready),
    .o_data  (w_head),
    .o_valid (ev_valid),
    .o_drop  (w_drop)
  );

  assign ev_code  = w_head.code;
  assign ev_ext   = w_head.ext;
  assign ev_break = w_head.brk;

  always_ff @(posedge CLOCK_50) begin
    if (reset)       r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  assign overflow = r_overflow;

`ifdef PS2_LOCK_TRACK_EN
  logic [2:0] r_lock;
  logic [2:0] r_held;

  // Held flags suppress re-toggling on typematic repeats until the key is released.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_lock <= '0;
      r_held <= '0;
    end else if (w_emit && !w_ext) begin
      for (int unsigned k = 0; k < 3; k++) begin
        if (scan_code == LOCK_KEYS[k]) begin
          if (w_brk) begin
            r_held[k] <= 1'b0;
          end else begin
            if (!r_held[k]) r_lock[k] <= ~r_lock[k];
            r_held[k] <= 1'b1;
          end
        end
      end
    end
  end

  assign ps2_lock_control = r_lock;
`else
  assign ps2_lock_control = '0;
`endif

endmodule
